// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: powers the oscillator up, waits for it to
// settle, then counts its synchronized rising edges over a programmable window.
module ring_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc_in,
    output logic              pd,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    // Window timer must hold both the full gate range and the settle count.
    localparam int TW = (GATE_W > 8) ? GATE_W : 8;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [2:0]          sync_q, sync_d;
    logic                osc_edge;
    logic [TW-1:0]       gate_ext;

    assign sync_d   = {sync_q[1:0], osc_in};
    assign osc_edge = sync_q[1] & ~sync_q[2];
    assign gate_ext = TW'(gate_q);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        gate_d  = gate_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (!abort && start && gate_len != '0) begin
                    state_d = SETTLE;
                    gate_d  = gate_len;
                    tmr_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
                    state_d = MEASURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (osc_edge) begin
                        // Saturate; an edge that cannot be counted flags overflow.
                        if (count_q == '1) ovf_d = 1'b1;
                        else               count_d = count_q + 1'b1;
                    end
                    if (tmr_q == gate_ext - 1'b1) state_d = DONE;
                    else                          tmr_d   = tmr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            gate_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            gate_q  <= gate_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
        end
    end

    assign busy     = (state_q == SETTLE) || (state_q == MEASURE);
    assign pd       = ~busy;
    assign done     = (state_q == DONE);
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: stimulus queues expected results,
// a negedge monitor checks each done pulse against them.
module tb_ring_freq_meter;
    localparam int CNT_W = 4;
    localparam int GATE_W = 16;
    localparam int S = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [GATE_W-1:0] gate_len = '0;
    logic              osc_in = 1'b0;
    logic              pd, busy, done, overflow;
    logic [CNT_W-1:0]  count;

    typedef struct {int cyc; int cnt; int ovf;} exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int osc_half = 4;
    int t0;

    ring_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .osc_in(osc_in), .pd(pd), .busy(busy),
        .done(done), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running oscillator model; toggles every osc_half clk cycles.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (osc_half != 0) begin
                ph++;
                if (ph >= osc_half) begin
                    osc_in = ~osc_in;
                    ph = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_count", int'(count), e.cnt);
                chk("done_overflow", int'(overflow), e.ovf);
            end
        end
    end

    task automatic start_meas(input int g, input bit push, input int ecnt, input int eovf);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        gate_len = GATE_W'(g);
        t0 = cyc;
        if (push) begin
            e.cyc = t0 + S + g + 1;
            e.cnt = ecnt;
            e.ovf = eovf;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_q(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("wait_timeout_pending", q.size(), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_pd"}, int'(pd), 1);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    initial begin
        #3;
        chk_idle("reset");
        chk("reset_count", int'(count), 0);
        chk("reset_ovf", int'(overflow), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(4);

        // Nominal: period 8, gate 64 -> 8 edges, done at T+69.
        osc_half = 4;
        start_meas(64, 1'b1, 8, 0);
        chk("nom_pd_T1", int'(pd), 0);
        chk("nom_busy_T1", int'(busy), 1);
        wait_q(200);
        chk_idle("nom_after");
        chk("nom_hold_count", int'(count), 8);

        // gate_len==0 ignored.
        start_meas(0, 1'b0, 0, 0);
        chk("gate0_busy", int'(busy), 0);
        wait_cycles(3);
        chk_idle("gate0_later");
        chk("gate0_hold_count", int'(count), 8);

        // Start during MEASURE with another gate length is ignored.
        start_meas(16, 1'b1, 2, 0);
        wait_cycles(6);
        start = 1'b1; gate_len = 16'd40;
        wait_cycles(1);
        start = 1'b0;
        wait_q(100);

        // Saturation: period 4, gate 100 -> 25 edges into a 4-bit counter.
        osc_half = 2;
        start_meas(100, 1'b1, 15, 1);
        wait_q(200);
        chk("sat_hold_count", int'(count), 15);
        chk("sat_hold_ovf", int'(overflow), 1);
        osc_half = 4;
        start_meas(8, 1'b1, 1, 0);
        chk("sat_clear_count", int'(count), 0);
        chk("sat_clear_ovf", int'(overflow), 0);
        wait_q(100);

        // Abort on the 10th MEASURE cycle (T+S+10).
        start_meas(64, 1'b0, 0, 0);
        wait_cycles(S + 10 - 1);
        chk("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        chk_idle("abort");
        chk("abort_count", int'(count), 0);
        chk("abort_ovf", int'(overflow), 0);
        wait_cycles(80);

        // Abort beats start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; gate_len = 16'd8;
        wait_cycles(1);
        start = 1'b0; abort = 1'b0;
        chk("abort_prio_busy", int'(busy), 0);

        // Abort during DONE keeps the pulse.
        start_meas(8, 1'b1, 1, 0);
        wait_cycles(S + 8);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        wait_q(20);

        // Reset mid-MEASURE for 3 cycles, then a full measurement.
        start_meas(64, 1'b0, 0, 0);
        wait_cycles(20);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_ovf", int'(overflow), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(80);
        start_meas(64, 1'b1, 8, 0);
        wait_q(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_freq_meter.md
RING_FREQ_METER -- requirements
Module: ring_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the edge counter and result.
REQ-002 SHALL have parameter GATE_W, default 16: width of the gate-length input.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: number of clk cycles the oscillator runs after power-up before counting starts (legal range 1..255).
REQ-004 SHALL have port clk  input  1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1: measurement request; one-cycle pulse or level.
REQ-007 SHALL have port abort  input  1: cancels any measurement in progress.
REQ-008 SHALL have port gate_len  input  GATE_W: measurement window length in clk cycles.
REQ-009 SHALL have port osc_in  input  1: divided ring-oscillator output, asynchronous to clk, frequency at most clk/4.
REQ-010 SHALL have port pd  output  1: oscillator power-down; 1 = oscillator off.
REQ-011 SHALL have port busy  output  1: high while in SETTLE or MEASURE.
REQ-012 SHALL have port done  output  1: one-cycle pulse marking a valid result.
REQ-013 SHALL have port count  output  CNT_W: number of osc_in rising edges counted in the last completed window.
REQ-014 SHALL have port overflow  output  1: sticky flag set when count saturated in the last window.

Function
REQ-015 SHALL sample osc_in through a 2-flop synchronizer; a third flop SHALL feed a rising-edge detector (edge = sync2 & ~sync3).
REQ-016 SHALL implement the states IDLE, SETTLE, MEASURE and DONE; the state register SHALL be the only control state.
REQ-017 In IDLE, start=1 with gate_len!=0 and abort=0 SHALL latch gate_len, clear count and overflow, and go to SETTLE on the next cycle.
REQ-018 start with gate_len==0 SHALL be ignored; the state SHALL remain IDLE and no done pulse SHALL be produced.
REQ-019 start SHALL be ignored in SETTLE, MEASURE and DONE; the latched gate_len SHALL NOT change mid-measurement.
REQ-020 pd SHALL be 0 in SETTLE and MEASURE and 1 in IDLE and DONE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles; edges detected in SETTLE SHALL NOT be counted.
REQ-022 MEASURE SHALL last exactly the latched gate_len cycles; each MEASURE cycle with edge=1 SHALL increment count by 1.
REQ-023 count SHALL saturate at 2^CNT_W-1; an edge arriving while count is saturated SHALL set overflow, and overflow SHALL stay set until the next accepted start or reset.
REQ-024 After the last MEASURE cycle the block SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-025 Latency: for start accepted at cycle T, SETTLE SHALL span T+1..T+S, MEASURE T+S+1..T+S+G, and done SHALL be high at T+S+G+1 (S=SETTLE_CYCLES, G=gate_len).
REQ-026 count and overflow SHALL hold their value from DONE until the next accepted start.
REQ-027 abort=1 in SETTLE or MEASURE SHALL return the block to IDLE on the next cycle with pd=1, count=0, overflow=0, and no done pulse.
REQ-028 abort=1 in DONE SHALL NOT suppress that done pulse; abort has priority over start when both are asserted in IDLE.
REQ-029 The internal window counters SHALL be wide enough that GATE_W all-ones and SETTLE_CYCLES=255 do not wrap.

Reset
REQ-030 When rst_n=0, the block SHALL immediately force state=IDLE, pd=1, busy=0, done=0, count=0, overflow=0, and clear the synchronizer flops to 0.
REQ-031 Reset asserted mid-measurement SHALL discard the measurement with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-032 Nominal: SETTLE_CYCLES=4, gate_len=64, osc_in period 8 clk, start at cycle T -> pd=0 from T+1, done=1 at T+69, count=8, overflow=0.
REQ-033 Saturation: CNT_W=4, gate_len=100, osc_in period 4 clk -> count=15, overflow=1 at done; next start clears both.
REQ-034 Abort: abort pulsed at the 10th MEASURE cycle -> IDLE next cycle, pd=1, count=0, no done pulse.
REQ-035 Ignored requests: start with gate_len=0 -> no state change; start during MEASURE with a different gate_len -> window length unchanged.
REQ-036 Reset mid-MEASURE: rst_n low for 3 cycles -> all outputs at reset values immediately; a subsequent start runs a full correct measurement.
